// File: rtl/hs_dpath_sfr_ce_ctrl_pkg.sv
// Shared helpers for the hs_dpath stream-pipeline controllers.
package hs_dpath_sfr_ce_ctrl_pkg;

   // Bits needed to hold values 0..value-1. Returns at least 1, so a
   // one-state counter still gets a real port.
   function automatic int hs_clog2(input int value);
      int w;
      w = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) begin
            w = i + 1;
         end
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/hs_dpath_sfr_ce_ctrl.sv
// Valid/ready controller for an hs_dpath_sfr_ce datapath of equal LATENCY.
// Tracks one valid bit per SFR stage and drives the shared clock enable, so
// the SFR behaves as a stallable, flushable stream pipeline. Payload never
// passes through here: it rides on the SFR din/dout alongside these handshakes.
module hs_dpath_sfr_ce_ctrl
   import hs_dpath_sfr_ce_ctrl_pkg::*;
#(
   parameter int LATENCY   = 1,
   parameter bit GATE_IDLE = 1'b1,
   parameter int CNT_W     = hs_clog2(LATENCY + 1)
) (
   input  logic               clk,
   input  logic               aresetn,
   input  logic               flush,
   input  logic               s_valid,
   output logic               s_ready,
   output logic               m_valid,
   input  logic               m_ready,
   output logic               ce,
   output logic [LATENCY-1:0] stage_vld,
   output logic [CNT_W-1:0]   occupancy,
   output logic               idle
);

   logic               advance;
   logic               accept;
   logic               pop;
   logic [LATENCY-1:0] stage_nxt;

   // Global stall: the whole pipeline moves together or not at all, with no
   // bubble collapsing. Flush freezes everything for its one cycle.
   always_comb begin
      m_valid = stage_vld[LATENCY-1];
      idle    = (occupancy == '0);
      advance = !flush && (!m_valid || m_ready);
      s_ready = advance;
      ce      = advance && (GATE_IDLE ? (s_valid || !idle) : 1'b1);
      accept  = s_valid && s_ready;
      pop     = m_valid && m_ready && !flush;
   end

   // Next valid chain on an enable: new beat (or bubble) enters stage 0.
   always_comb begin
      stage_nxt    = stage_vld << 1;
      stage_nxt[0] = accept;
   end

   // Valid chain: cleared by flush, shifted on ce, held otherwise.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         stage_vld <= '0;
      end else if (flush) begin
         stage_vld <= '0;
      end else if (ce) begin
         stage_vld <= stage_nxt;
      end
   end

   // Occupancy counter; accept and pop in the same cycle cancel out.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         occupancy <= '0;
      end else if (flush) begin
         occupancy <= '0;
      end else begin
         occupancy <= occupancy + CNT_W'(accept) - CNT_W'(pop);
      end
   end

   a_occ_matches_chain: assert property (
      @(posedge clk) disable iff (!aresetn)
      occupancy == CNT_W'($countones(stage_vld)));

   a_occ_bounded: assert property (
      @(posedge clk) disable iff (!aresetn)
      int'(occupancy) <= LATENCY);

   a_mvalid_held: assert property (
      @(posedge clk) disable iff (!aresetn)
      (m_valid && !m_ready && !flush) |=> m_valid);

endmodule
